// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences each instruction through the shared datapath
// and drives its control strobes, with memory wait states, illegal trapping and a retire counter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned IMMSRC_W    = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                adr_src_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          result_src_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          alu_op_o,
  output logic [IMMSRC_W-1:0] imm_src_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    instr_retired_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_LUI, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_c, retire_c, pc_update_c, branch_c;

  assign rdy_c           = mem_ready_i | (MEM_WAIT_EN == 0);
  assign instr_retired_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state and Moore outputs; rst masks every strobe in the reset cycle itself.
  always_comb begin
    state_d      = state_q;
    retire_c     = 1'b0;
    pc_update_c  = 1'b0;
    branch_c     = 1'b0;
    adr_src_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = rdy_c;
        pc_update_c  = rdy_c;
        if (rdy_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (rdy_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (rdy_c) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b11;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        branch_c    = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        result_src_o = 2'b11;
        reg_write_o  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  illegal_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
    pc_write_o = pc_update_c | (branch_c & zero_i);
    if (rst) begin
      pc_write_o   = 1'b0;
      adr_src_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      illegal_o    = 1'b0;
    end
  end

  // Immediate format follows the IR opcode in every state.
  always_comb begin
    case (op_i)
      OP_STORE: imm_src_o = IMMSRC_W'(3'd1);
      OP_BEQ:   imm_src_o = IMMSRC_W'(3'd2);
      OP_JAL:   imm_src_o = IMMSRC_W'(3'd3);
      OP_LUI:   imm_src_o = IMMSRC_W'(3'd4);
      default:  imm_src_o = IMMSRC_W'(3'd0);
    endcase
    if (rst) imm_src_o = '0;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction expected cycle scripts built from the instruction rules,
// replayed against the DUT with directed and randomized instruction streams.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, BAD = 7'b1111111;

  logic clk = 1'b0, rst = 1'b1, zero_i = 1'b0, mem_ready_i = 1'b1;
  logic [6:0] op_i = 7'd0;
  logic pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_a, alu_b, alu_op;
  logic [2:0] imm_src;
  logic [31:0] retired;
  logic d4_pcw, d4_adr, d4_req, d4_mw, d4_irw, d4_rw, d4_ill;
  logic [1:0] d4_rs, d4_a, d4_b, d4_op;
  logic [2:0] d4_imm;
  logic [3:0] d4_cnt;
  logic [13:0] ctrl_w;

  int checks = 0, errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef struct packed {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic        retire;
    logic [13:0] ctrl;
  } cyc_t;
  cyc_t scr[$];
  logic [6:0] b_op;
  logic       b_zero;
  bit         b_scr;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_req_o(mem_req), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_write_o(reg_write), .result_src_o(result_src),
    .alu_src_a_o(alu_a), .alu_src_b_o(alu_b), .alu_op_o(alu_op), .imm_src_o(imm_src),
    .illegal_o(illegal), .instr_retired_o(retired)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(d4_pcw), .adr_src_o(d4_adr), .mem_req_o(d4_req), .mem_write_o(d4_mw),
    .ir_write_o(d4_irw), .reg_write_o(d4_rw), .result_src_o(d4_rs),
    .alu_src_a_o(d4_a), .alu_src_b_o(d4_b), .alu_op_o(d4_op), .imm_src_o(d4_imm),
    .illegal_o(d4_ill), .instr_retired_o(d4_cnt)
  );

  assign ctrl_w = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                   result_src, alu_a, alu_b, alu_op};

  function automatic logic [13:0] ctl(input int pcw, adr, req, mw, irw, rw, rs, a, b, op);
    return {1'(pcw), 1'(adr), 1'(req), 1'(mw), 1'(irw), 1'(rw), 2'(rs), 2'(a), 2'(b), 2'(op)};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      SW: return 3'd1;
      BQ: return 3'd2;
      JL: return 3'd3;
      LU: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // rdy < 0 means memory ready is irrelevant in that cycle; keep = op/zero must be the instruction's
  function automatic void push_c(input logic [13:0] c, input int rdy, input bit keep, input bit ret);
    cyc_t e;
    e.ctrl   = c;
    e.retire = ret;
    e.rdy    = (rdy < 0) ? (b_scr ? 1'($urandom) : 1'b1) : 1'(rdy);
    e.op     = (keep || !b_scr) ? b_op : 7'($urandom);
    e.zero   = (keep || !b_scr) ? b_zero : 1'($urandom);
    scr.push_back(e);
  endfunction

  function automatic void build(input logic [6:0] op, input logic z, input int fw, input int mw,
                                input bit s);
    b_op = op; b_zero = z; b_scr = s;
    for (int i = 0; i < fw; i++) push_c(ctl(0,0,1,0,0,0,2,0,2,0), 0, 0, 0);
    push_c(ctl(1,0,1,0,1,0,2,0,2,0), 1, 0, 0);
    push_c(ctl(0,0,0,0,0,0,0,1,1,0), -1, 1, 0);
    case (op)
      LW: begin
        push_c(ctl(0,0,0,0,0,0,0,2,1,0), -1, 1, 0);
        for (int i = 0; i < mw; i++) push_c(ctl(0,1,1,0,0,0,0,0,0,0), 0, 0, 0);
        push_c(ctl(0,1,1,0,0,0,0,0,0,0), 1, 0, 0);
        push_c(ctl(0,0,0,0,0,1,1,0,0,0), -1, 0, 1);
      end
      SW: begin
        push_c(ctl(0,0,0,0,0,0,0,2,1,0), -1, 1, 0);
        for (int i = 0; i < mw; i++) push_c(ctl(0,1,1,1,0,0,0,0,0,0), 0, 0, 0);
        push_c(ctl(0,1,1,1,0,0,0,0,0,0), 1, 0, 1);
      end
      RT: begin
        push_c(ctl(0,0,0,0,0,0,0,2,0,2), -1, 0, 0);
        push_c(ctl(0,0,0,0,0,1,0,0,0,0), -1, 0, 1);
      end
      IT: begin
        push_c(ctl(0,0,0,0,0,0,0,2,1,3), -1, 0, 0);
        push_c(ctl(0,0,0,0,0,1,0,0,0,0), -1, 0, 1);
      end
      BQ: push_c(ctl(int'(z),0,0,0,0,0,0,2,0,1), -1, 1, 1);
      JL: begin
        push_c(ctl(1,0,0,0,0,0,0,1,2,0), -1, 0, 0);
        push_c(ctl(0,0,0,0,0,1,0,0,0,0), -1, 0, 1);
      end
      LU: push_c(ctl(0,0,0,0,0,1,3,0,0,0), -1, 0, 1);
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; op_i = SW; mem_ready_i = 1'b1; zero_i = 1'b1;
    @(negedge clk); #2;
    checks++; if (ctrl_w !== 14'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", ctrl_w); end
    checks++; if (imm_src !== 3'd0) begin errors++; $display("FAIL reset_imm got %0d exp 0", imm_src); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", retired); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_sequences();
    scr.delete();
    build(RT, 1'b0, 0, 0, 0);
    build(LW, 1'b0, 0, 3, 0);
    build(BQ, 1'b1, 0, 0, 0);
    build(BQ, 1'b0, 0, 0, 0);
    build(JL, 1'b0, 0, 0, 0);
    build(LU, 1'b0, 0, 0, 0);
    build(SW, 1'b0, 1, 2, 0);
    build(IT, 1'b0, 2, 0, 0);
    foreach (scr[k]) begin
      @(negedge clk); rst = 1'b0; op_i = scr[k].op; zero_i = scr[k].zero; mem_ready_i = scr[k].rdy; #2;
      checks++; if (ctrl_w !== scr[k].ctrl) begin errors++; $display("FAIL seq_ctrl cyc %0d got %b exp %b", k, ctrl_w, scr[k].ctrl); end
      checks++; if (imm_src !== imm_of(scr[k].op)) begin errors++; $display("FAIL seq_imm cyc %0d got %0d exp %0d", k, imm_src, imm_of(scr[k].op)); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL seq_illegal cyc %0d got %b exp 0", k, illegal); end
      checks++; if (retired !== exp_cnt) begin errors++; $display("FAIL seq_cnt cyc %0d got %0d exp %0d", k, retired, exp_cnt); end
      if (scr[k].retire) exp_cnt++;
    end
  endtask

  task automatic test_trap();
    logic [31:0] frozen;
    do_reset();
    scr.delete();
    build(RT, 1'b0, 0, 0, 0);
    build(BAD, 1'b0, 1, 0, 0);
    foreach (scr[k]) begin
      @(negedge clk); rst = 1'b0; op_i = scr[k].op; zero_i = scr[k].zero; mem_ready_i = scr[k].rdy; #2;
      checks++; if (ctrl_w !== scr[k].ctrl) begin errors++; $display("FAIL trap_pre_ctrl cyc %0d got %b exp %b", k, ctrl_w, scr[k].ctrl); end
      checks++; if (retired !== exp_cnt) begin errors++; $display("FAIL trap_pre_cnt cyc %0d got %0d exp %0d", k, retired, exp_cnt); end
      if (scr[k].retire) exp_cnt++;
    end
    frozen = exp_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); op_i = 7'($urandom); zero_i = 1'($urandom); mem_ready_i = 1'($urandom); #2;
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL trap_illegal cyc %0d got %b exp 1", i, illegal); end
      checks++; if (ctrl_w !== 14'd0) begin errors++; $display("FAIL trap_ctrl cyc %0d got %b exp 0", i, ctrl_w); end
      checks++; if (imm_src !== imm_of(op_i)) begin errors++; $display("FAIL trap_imm cyc %0d got %0d exp %0d", i, imm_src, imm_of(op_i)); end
      checks++; if (retired !== frozen) begin errors++; $display("FAIL trap_cnt cyc %0d got %0d exp %0d", i, retired, frozen); end
    end
    @(negedge clk); rst = 1'b1; #2;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL trap_rst_illegal got %b exp 0", illegal); end
    @(negedge clk); rst = 1'b0; mem_ready_i = 1'b1; op_i = RT; exp_cnt = 32'd0; #2;
    checks++; if (ctrl_w !== ctl(1,0,1,0,1,0,2,0,2,0)) begin errors++; $display("FAIL trap_exit_fetch got %b exp %b", ctrl_w, ctl(1,0,1,0,1,0,2,0,2,0)); end
    checks++; if (retired !== 32'd0 || illegal !== 1'b0) begin errors++; $display("FAIL trap_exit_state cnt %0d illegal %b exp 0 0", retired, illegal); end
  endtask

  task automatic test_store_reset();
    do_reset();
    scr.delete();
    build(SW, 1'b0, 0, 2, 0);
    void'(scr.pop_back());
    foreach (scr[k]) begin
      @(negedge clk); rst = 1'b0; op_i = scr[k].op; zero_i = scr[k].zero; mem_ready_i = scr[k].rdy; #2;
      checks++; if (ctrl_w !== scr[k].ctrl) begin errors++; $display("FAIL stres_ctrl cyc %0d got %b exp %b", k, ctrl_w, scr[k].ctrl); end
    end
    @(negedge clk); rst = 1'b1; mem_ready_i = 1'b1; #2;
    checks++; if (mem_write !== 1'b0 || ctrl_w !== 14'd0) begin errors++; $display("FAIL stres_rst_cycle memwrite %b ctrl %b exp 0", mem_write, ctrl_w); end
    @(negedge clk); rst = 1'b0; op_i = LU; exp_cnt = 32'd0; #2;
    checks++; if (ctrl_w !== ctl(1,0,1,0,1,0,2,0,2,0)) begin errors++; $display("FAIL stres_fetch got %b exp %b", ctrl_w, ctl(1,0,1,0,1,0,2,0,2,0)); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL stres_cnt got %0d exp 0", retired); end
  endtask

  task automatic test_random_stream();
    logic [6:0] pool [7];
    pool = '{LW, SW, RT, IT, BQ, JL, LU};
    do_reset();
    scr.delete();
    for (int n = 0; n < 60; n++)
      build(pool[$urandom_range(0, 6)], 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1);
    foreach (scr[k]) begin
      @(negedge clk); rst = 1'b0; op_i = scr[k].op; zero_i = scr[k].zero; mem_ready_i = scr[k].rdy; #2;
      checks++; if (ctrl_w !== scr[k].ctrl) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", k, ctrl_w, scr[k].ctrl); end
      checks++; if (imm_src !== imm_of(scr[k].op)) begin errors++; $display("FAIL rnd_imm cyc %0d got %0d exp %0d", k, imm_src, imm_of(scr[k].op)); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rnd_illegal cyc %0d got %b exp 0", k, illegal); end
      checks++; if (retired !== exp_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", k, retired, exp_cnt); end
      checks++; if (d4_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL rnd_cnt4_wrap cyc %0d got %0d exp %0d", k, d4_cnt, exp_cnt[3:0]); end
      if (scr[k].retire) exp_cnt++;
    end
    @(negedge clk); #2;
    checks++; if (retired !== 32'd60) begin errors++; $display("FAIL rnd_total got %0d exp 60", retired); end
    checks++; if (d4_cnt !== 4'd12) begin errors++; $display("FAIL rnd_total4 got %0d exp 12", d4_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_trap();
    test_store_reset();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
